mem_access_stage: RTL and testbench

- Pipeline stage directly upstream of the write-back stage.
- Accepts one instruction per handshake from the execute stage and completes outstanding data-SRAM load responses.
- Aligns and extends load data, then presents a registered result plus exception info to write-back.
- On a write-back flush, drops its instruction and discards any orphaned SRAM responses.

---
 rtl/mem_access_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access stage: completes data-SRAM loads, aligns/extends data, hands a result to write-back.
// Latency: one cycle from execute handshake to ms_to_ws_valid; loads also wait for their data_ok.
// Backpressure: a response arriving while write-back stalls is held in a one-entry buffer; ms_allowin drops until handoff.
// Optional macro MS_LOAD_FWD_EN: ms_fwd_blk releases in the cycle the load's data_ok arrives.
module mem_access_stage #(
    parameter int PC_WD          = 32,
    parameter int DATA_WD        = 32,
    parameter int DISCARD_CNT_WD = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               es_to_ms_valid,
    output logic               ms_allowin,
    input  logic [PC_WD-1:0]   es_pc,
    input  logic [DATA_WD-1:0] es_alu_result,
    input  logic [4:0]         es_dest,
    input  logic               es_gr_we,
    input  logic               es_mem_req,
    input  logic [2:0]         es_load_op,
    input  logic               es_ex,
    input  logic [5:0]         es_ecode,
    input  logic               data_sram_data_ok,
    input  logic [DATA_WD-1:0] data_sram_rdata,
    input  logic               flush,
    output logic               ms_to_ws_valid,
    input  logic               ws_allowin,
    output logic [PC_WD-1:0]   ms_pc,
    output logic [DATA_WD-1:0] ms_final_result,
    output logic [4:0]         ms_dest,
    output logic               ms_gr_we,
    output logic               ms_ex,
    output logic [5:0]         ms_ecode,
    output logic               ms_fwd_valid,
    output logic               ms_fwd_blk
);
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [DISCARD_CNT_WD-1:0] CNT_MAX = '1;

    logic               ms_valid;
    logic [DATA_WD-1:0] alu_r;
    logic               gr_we_r;
    logic               mem_req_r;
    logic [2:0]         load_op_r;
    logic               data_buf_valid;
    logic [DATA_WD-1:0] data_buf;
    logic [DISCARD_CNT_WD-1:0] discard_cnt;

    logic               ms_ready_go;
    logic               cnt_zero;
    logic               resp_take;
    logic               buf_set;
    logic               inc_cur;
    logic               inc_es;
    logic               dec;
    logic [DISCARD_CNT_WD+1:0] cnt_sum;
    logic [DISCARD_CNT_WD-1:0] cnt_next;
    logic [DATA_WD-1:0] src;
    logic [DATA_WD-1:0] shifted;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic               fwd_blk_base;

    // A response belongs to the current load only when no orphans are still in flight.
    assign cnt_zero    = (discard_cnt == '0);
    assign resp_take   = data_sram_data_ok & cnt_zero;
    assign ms_ready_go = ~mem_req_r | ms_ex | data_buf_valid | resp_take;
    assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;
    assign buf_set     = resp_take & ms_valid & mem_req_r & ~data_buf_valid & ~ws_allowin;

    // Orphan accounting: the in-stage load only counts if its data is not arriving right now.
    assign inc_cur = flush & ms_valid & mem_req_r & ~data_buf_valid & ~resp_take;
    assign inc_es  = flush & es_to_ms_valid & es_mem_req & ms_allowin;
    assign dec     = data_sram_data_ok & ~cnt_zero;

    // Net increment/decrement with saturation at the counter maximum.
    always_comb begin
        cnt_sum = {2'b00, discard_cnt};
        cnt_sum = cnt_sum + (DISCARD_CNT_WD+2)'(inc_cur) + (DISCARD_CNT_WD+2)'(inc_es);
        if (dec) begin
            cnt_sum = cnt_sum - (DISCARD_CNT_WD+2)'(1);
        end
        cnt_next = (cnt_sum > {2'b00, CNT_MAX}) ? CNT_MAX : cnt_sum[DISCARD_CNT_WD-1:0];
    end

    // Stage valid bit: flush kills the instruction, otherwise advance on allowin.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
        end else if (flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    // Capture the execute-stage fields on a handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_pc     <= '0;
            alu_r     <= '0;
            ms_dest   <= '0;
            gr_we_r   <= 1'b0;
            mem_req_r <= 1'b0;
            load_op_r <= '0;
            ms_ex     <= 1'b0;
            ms_ecode  <= '0;
        end else if (ms_allowin && es_to_ms_valid) begin
            ms_pc     <= es_pc;
            alu_r     <= es_alu_result;
            ms_dest   <= es_dest;
            gr_we_r   <= es_gr_we;
            mem_req_r <= es_mem_req;
            load_op_r <= es_load_op;
            ms_ex     <= es_ex;
            ms_ecode  <= es_ecode;
        end
    end

    // One-entry response buffer for data arriving while write-back stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_buf_valid <= 1'b0;
            data_buf       <= '0;
        end else if (flush || (ms_ready_go && ws_allowin)) begin
            data_buf_valid <= 1'b0;
        end else if (buf_set) begin
            data_buf_valid <= 1'b1;
            data_buf       <= data_sram_rdata;
        end
    end

    // Orphaned-response counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            discard_cnt <= '0;
        end else begin
            discard_cnt <= cnt_next;
        end
    end

    // Load alignment and sign/zero extension; non-loads pass the ALU result.
    always_comb begin
        src      = data_buf_valid ? data_buf : data_sram_rdata;
        shifted  = src >> {alu_r[1:0], 3'b000};
        byte_sel = shifted[7:0];
        half_sel = alu_r[1] ? src[31:16] : src[15:0];
        case (load_op_r)
            OP_LW:   ms_final_result = src;
            OP_LB:   ms_final_result = {{(DATA_WD-8){byte_sel[7]}}, byte_sel};
            OP_LBU:  ms_final_result = {{(DATA_WD-8){1'b0}}, byte_sel};
            OP_LH:   ms_final_result = {{(DATA_WD-16){half_sel[15]}}, half_sel};
            OP_LHU:  ms_final_result = {{(DATA_WD-16){1'b0}}, half_sel};
            default: ms_final_result = alu_r;
        endcase
    end

    assign ms_gr_we     = gr_we_r & ~ms_ex;
    assign ms_fwd_valid = ms_valid & ms_gr_we;
    assign fwd_blk_base = ms_valid & gr_we_r & mem_req_r & ~ms_ex & ~data_buf_valid;

`ifdef MS_LOAD_FWD_EN
    assign ms_fwd_blk = fwd_blk_base & ~resp_take;
`else
    assign ms_fwd_blk = fwd_blk_base;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    logic        clk;
    logic        resetn;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_alu_result;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        es_mem_req;
    logic [2:0]  es_load_op;
    logic        es_ex;
    logic [5:0]  es_ecode;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        flush;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [31:0] ms_final_result;
    logic [4:0]  ms_dest;
    logic        ms_gr_we;
    logic        ms_ex;
    logic [5:0]  ms_ecode;
    logic        ms_fwd_valid;
    logic        ms_fwd_blk;

    int checks = 0;
    int failures = 0;

`ifdef MS_LOAD_FWD_EN
    localparam logic BLK_AT_OK = 1'b0;
`else
    localparam logic BLK_AT_OK = 1'b1;
`endif

    mem_access_stage #(.PC_WD(32), .DATA_WD(32), .DISCARD_CNT_WD(2)) dut (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_alu_result(es_alu_result), .es_dest(es_dest),
        .es_gr_we(es_gr_we), .es_mem_req(es_mem_req), .es_load_op(es_load_op),
        .es_ex(es_ex), .es_ecode(es_ecode),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .flush(flush), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_final_result(ms_final_result), .ms_dest(ms_dest),
        .ms_gr_we(ms_gr_we), .ms_ex(ms_ex), .ms_ecode(ms_ecode),
        .ms_fwd_valid(ms_fwd_valid), .ms_fwd_blk(ms_fwd_blk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single handshake cycle (stage must be accepting).
    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [2:0] op,
                         input logic req, input logic ex, input logic [5:0] ec);
        es_to_ms_valid = 1'b1; es_pc = pc; es_alu_result = alu; es_dest = 5'd7;
        es_gr_we = 1'b1; es_mem_req = req; es_load_op = op; es_ex = ex; es_ecode = ec;
        tick;
        es_to_ms_valid = 1'b0; es_mem_req = 1'b0; es_ex = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL reset_to_ws: got %b want 0", ms_to_ws_valid); end
        checks++; if (ms_fwd_valid !== 1'b0) begin failures++; $display("FAIL reset_fwd_valid: got %b want 0", ms_fwd_valid); end
        checks++; if (ms_fwd_blk !== 1'b0) begin failures++; $display("FAIL reset_fwd_blk: got %b want 0", ms_fwd_blk); end
        checks++; if (ms_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 0", ms_pc); end
        checks++; if (ms_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin: got %b want 1", ms_allowin); end
        tick;
        resetn = 1'b1;
        tick;
    endtask

    task automatic test_passthrough;
        issue(32'h100, 32'h1234, 3'd7, 1'b0, 1'b0, 6'd0);
        checks++; if (ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL alu_to_ws: got %b want 1", ms_to_ws_valid); end
        checks++; if (ms_final_result !== 32'h1234) begin failures++; $display("FAIL alu_result: got %h want 00001234", ms_final_result); end
        checks++; if (ms_fwd_blk !== 1'b0) begin failures++; $display("FAIL alu_fwd_blk: got %b want 0", ms_fwd_blk); end
        checks++; if (ms_fwd_valid !== 1'b1) begin failures++; $display("FAIL alu_fwd_valid: got %b want 1", ms_fwd_valid); end
        checks++; if (ms_pc !== 32'h100 || ms_dest !== 5'd7) begin failures++; $display("FAIL alu_fields: got pc=%h dest=%0d want 100/7", ms_pc, ms_dest); end
        tick;
        checks++; if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL alu_drain: got %b want 0", ms_to_ws_valid); end
    endtask

    // Load with data_ok two cycles after issue, write-back always ready.
    task automatic test_load(input string nm, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] rd, input logic [31:0] exp);
        issue(32'h200, addr, op, 1'b1, 1'b0, 6'd0);
        checks++; if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL %s_stall1: got allowin=%b to_ws=%b want 0/0", nm, ms_allowin, ms_to_ws_valid); end
        checks++; if (ms_fwd_blk !== 1'b1) begin failures++; $display("FAIL %s_fwd_blk: got %b want 1", nm, ms_fwd_blk); end
        tick;
        checks++; if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL %s_stall2: got allowin=%b to_ws=%b want 0/0", nm, ms_allowin, ms_to_ws_valid); end
        data_sram_data_ok = 1'b1; data_sram_rdata = rd;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1) begin failures++; $display("FAIL %s_done: got to_ws=%b allowin=%b want 1/1", nm, ms_to_ws_valid, ms_allowin); end
        checks++; if (ms_final_result !== exp) begin failures++; $display("FAIL %s_result: got %h want %h", nm, ms_final_result, exp); end
        checks++; if (ms_fwd_blk !== BLK_AT_OK) begin failures++; $display("FAIL %s_blk_at_ok: got %b want %b", nm, ms_fwd_blk, BLK_AT_OK); end
        tick;
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL %s_drain: got %b want 0", nm, ms_to_ws_valid); end
    endtask

    task automatic test_backpressure;
        ws_allowin = 1'b0;
        issue(32'h300, 32'h2002, 3'd3, 1'b1, 1'b0, 6'd0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF_0000;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin failures++; $display("FAIL bp_hold: got to_ws=%b allowin=%b want 1/0", ms_to_ws_valid, ms_allowin); end
        tick;
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h1234_5678;
        #1;
        checks++; if (dut.data_buf_valid !== 1'b1) begin failures++; $display("FAIL bp_buf_valid: got %b want 1", dut.data_buf_valid); end
        checks++; if (ms_final_result !== 32'hFFFF_BEEF) begin failures++; $display("FAIL bp_buf_result: got %h want ffffbeef", ms_final_result); end
        checks++; if (ms_fwd_blk !== 1'b0 || ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL bp_buf_state: got blk=%b to_ws=%b want 0/1", ms_fwd_blk, ms_to_ws_valid); end
        ws_allowin = 1'b1;
        #1;
        checks++; if (ms_allowin !== 1'b1 || ms_final_result !== 32'hFFFF_BEEF) begin failures++; $display("FAIL bp_release: got allowin=%b res=%h want 1/ffffbeef", ms_allowin, ms_final_result); end
        tick;
        checks++; if (ms_to_ws_valid !== 1'b0 || dut.data_buf_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got to_ws=%b buf=%b want 0/0", ms_to_ws_valid, dut.data_buf_valid); end
        data_sram_rdata = 32'h0;
    endtask

    task automatic test_flush_orphan;
        issue(32'h400, 32'h3000, 3'd0, 1'b1, 1'b0, 6'd0);
        flush = 1'b1;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL fl_to_ws: got %b want 0", ms_to_ws_valid); end
        tick;
        flush = 1'b0;
        #1;
        checks++; if (dut.discard_cnt !== 2'd1 || ms_fwd_valid !== 1'b0) begin failures++; $display("FAIL fl_count: got cnt=%0d fwd=%b want 1/0", dut.discard_cnt, ms_fwd_valid); end
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_DEAD;
        issue(32'h404, 32'h4000, 3'd0, 1'b1, 1'b0, 6'd0);
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0 || dut.discard_cnt !== 2'd0) begin failures++; $display("FAIL fl_orphan_ignored: got to_ws=%b cnt=%0d want 0/0", ms_to_ws_valid, dut.discard_cnt); end
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'hCAFE_F00D) begin failures++; $display("FAIL fl_next_load: got to_ws=%b res=%h want 1/cafef00d", ms_to_ws_valid, ms_final_result); end
        tick;
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        #1;
    endtask

    task automatic test_flush_with_data_ok;
        issue(32'h500, 32'h5000, 3'd0, 1'b1, 1'b0, 6'd0);
        flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL fd_to_ws: got %b want 0", ms_to_ws_valid); end
        tick;
        flush = 1'b0; data_sram_data_ok = 1'b0;
        #1;
        checks++; if (dut.discard_cnt !== 2'd0 || ms_fwd_valid !== 1'b0) begin failures++; $display("FAIL fd_count: got cnt=%0d fwd=%b want 0/0", dut.discard_cnt, ms_fwd_valid); end
    endtask

    task automatic test_exception;
        issue(32'h600, 32'h55, 3'd0, 1'b0, 1'b1, 6'h09);
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1) begin failures++; $display("FAIL ex_no_stall: got to_ws=%b allowin=%b want 1/1", ms_to_ws_valid, ms_allowin); end
        checks++; if (ms_ex !== 1'b1 || ms_gr_we !== 1'b0) begin failures++; $display("FAIL ex_flags: got ex=%b gr_we=%b want 1/0", ms_ex, ms_gr_we); end
        checks++; if (ms_ecode !== 6'h09) begin failures++; $display("FAIL ex_ecode: got %h want 09", ms_ecode); end
        checks++; if (ms_fwd_valid !== 1'b0 || ms_fwd_blk !== 1'b0) begin failures++; $display("FAIL ex_fwd: got valid=%b blk=%b want 0/0", ms_fwd_valid, ms_fwd_blk); end
        tick;
    endtask

    task automatic test_saturate;
        es_to_ms_valid = 1'b1; es_mem_req = 1'b1; es_load_op = 3'd0; flush = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        es_to_ms_valid = 1'b0; es_mem_req = 1'b0; flush = 1'b0;
        #1;
        checks++; if (dut.discard_cnt !== 2'd3 || ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL sat_max: got cnt=%0d to_ws=%b want 3/0", dut.discard_cnt, ms_to_ws_valid); end
        data_sram_data_ok = 1'b1;
        for (int i = 0; i < 3; i++) tick;
        data_sram_data_ok = 1'b0;
        #1;
        checks++; if (dut.discard_cnt !== 2'd0) begin failures++; $display("FAIL sat_drain: got cnt=%0d want 0", dut.discard_cnt); end
    endtask

    task automatic test_async_reset;
        issue(32'h700, 32'h7000, 3'd0, 1'b1, 1'b0, 6'd0);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        issue(32'h704, 32'h7004, 3'd0, 1'b1, 1'b0, 6'd0);
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0 || ms_fwd_valid !== 1'b0 || ms_fwd_blk !== 1'b0) begin failures++; $display("FAIL ar_ctrl: got to_ws=%b fwd=%b blk=%b want 0/0/0", ms_to_ws_valid, ms_fwd_valid, ms_fwd_blk); end
        checks++; if (ms_pc !== 32'h0 || ms_dest !== 5'd0 || ms_gr_we !== 1'b0) begin failures++; $display("FAIL ar_fields: got pc=%h dest=%0d we=%b want 0/0/0", ms_pc, ms_dest, ms_gr_we); end
        checks++; if (dut.discard_cnt !== 2'd0) begin failures++; $display("FAIL ar_count: got %0d want 0", dut.discard_cnt); end
        tick;
        resetn = 1'b1;
        tick;
        issue(32'h708, 32'h7008, 3'd0, 1'b1, 1'b0, 6'd0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hA5A5_5A5A;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'hA5A5_5A5A) begin failures++; $display("FAIL ar_after: got to_ws=%b res=%h want 1/a5a55a5a", ms_to_ws_valid, ms_final_result); end
        tick;
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; es_to_ms_valid = 1'b0; es_pc = '0; es_alu_result = '0; es_dest = '0;
        es_gr_we = 1'b0; es_mem_req = 1'b0; es_load_op = '0; es_ex = 1'b0; es_ecode = '0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0; flush = 1'b0; ws_allowin = 1'b1;
        test_reset;
        test_passthrough;
        test_load("lb", 3'd1, 32'h1003, 32'h80FF_0000, 32'hFFFF_FF80);
        test_load("lbu", 3'd2, 32'h1003, 32'h80FF_0000, 32'h0000_0080);
        test_load("lhu", 3'd4, 32'h2002, 32'hBEEF_0000, 32'h0000_BEEF);
        test_backpressure;
        test_flush_orphan;
        test_flush_with_data_ok;
        test_exception;
        test_saturate;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
